// File: rtl/sdr_dq_pipe.sv
`default_nettype none
// sdr_dq_pipe: registered SDRAM DQ/DQM/OE write path and CAS-latency aligned read capture
// with burst tracking, read interrupt and sticky bus-turnaround conflict flag.  Rev 1.0
module sdr_dq_pipe #(
   parameter int DSIZE       = 16,
   parameter int CAS_LATENCY = 3,
   parameter int BURST_LEN   = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [DSIZE-1:0]   DATAIN,
   input  logic [DSIZE/8-1:0] DM,
   input  logic               WR_EN,
   input  logic               RD_CMD,
   input  logic [DSIZE-1:0]   DQIN,
   output logic [DSIZE-1:0]   DQOUT,
   output logic [DSIZE/8-1:0] DQM,
   output logic               DQ_OE,
   output logic [DSIZE-1:0]   RDATA,
   output logic               RDATA_VALID,
   output logic               RD_BUSY,
   output logic               BUS_CONFLICT
);

   localparam int c_mw = DSIZE / 8;
   localparam int c_cw = $clog2(BURST_LEN + 1);
   // The command cycle itself issues beat 0, so only BURST_LEN-1 beats remain after it.
   localparam logic [c_cw-1:0] c_reload = c_cw'(BURST_LEN - 1);

   logic [c_cw-1:0]        cnt_q, cnt_d;
   logic [CAS_LATENCY-1:0] mark_q, mark_d;
   logic [DSIZE-1:0]       dqout_q, dqout_d;
   logic [DSIZE-1:0]       rdata_q, rdata_d;
   logic [c_mw-1:0]        dqm_q, dqm_d;
   logic                   oe_q, oe_d;
   logic                   valid_q, valid_d;
   logic                   busy_q, busy_d;
   logic                   conflict_q, conflict_d;

   logic                   cnt_nz;
   logic                   active;
   logic                   conflict;
   logic                   wr_ok;

   always_comb begin
      cnt_nz   = (cnt_q != '0);
      active   = RD_CMD | cnt_nz;
      conflict = WR_EN & (busy_q | RD_CMD);
      wr_ok    = WR_EN & ~conflict;

      if (RD_CMD) begin
         cnt_d = c_reload;
      end else if (cnt_nz) begin
         cnt_d = cnt_q - c_cw'(1);
      end else begin
         cnt_d = '0;
      end

      mark_d    = mark_q << 1;
      mark_d[0] = active;

      dqout_d = wr_ok ? DATAIN : dqout_q;
      if (wr_ok) begin
         dqm_d = DM;
      end else if (active) begin
         dqm_d = {c_mw{1'b0}};
      end else begin
         dqm_d = {c_mw{1'b1}};
      end
      oe_d = wr_ok;

      valid_d = mark_q[CAS_LATENCY-1];
      rdata_d = valid_d ? DQIN : rdata_q;

      // Held one cycle past the last valid beat to give the pads a turnaround gap.
      busy_d     = active | (|mark_q) | valid_q;
      conflict_d = conflict_q | conflict;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q      <= '0;
         mark_q     <= '0;
         dqout_q    <= '0;
         dqm_q      <= {c_mw{1'b1}};
         oe_q       <= 1'b0;
         rdata_q    <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         mark_q     <= mark_d;
         dqout_q    <= dqout_d;
         dqm_q      <= dqm_d;
         oe_q       <= oe_d;
         rdata_q    <= rdata_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

   assign DQOUT        = dqout_q;
   assign DQM          = dqm_q;
   assign DQ_OE        = oe_q;
   assign RDATA        = rdata_q;
   assign RDATA_VALID  = valid_q;
   assign RD_BUSY      = busy_q;
   assign BUS_CONFLICT = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_sdr_dq_pipe.sv
`default_nettype none
// tb_sdr_dq_pipe: four parameter sets driven by shared stimulus, checked every cycle
// against a beat-schedule reference model plus hand-computed directed expectations.
module tb_sdr_dq_pipe;

   localparam int NCFG = 4;
   localparam int MAXC = 4096;
   localparam int NCYC = 3000;
   localparam int T0   = 3;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] din, dqin;
   logic [3:0]  dm;
   logic        wr, rd;

   always #5 CLK = ~CLK;

   logic [15:0] a_dqout, a_rdata, b_dqout, b_rdata;
   logic [31:0] c_dqout, c_rdata, d_dqout, d_rdata;
   logic [1:0]  a_dqm, b_dqm;
   logic [3:0]  c_dqm, d_dqm;
   logic a_oe, a_v, a_busy, a_bc, b_oe, b_v, b_busy, b_bc;
   logic c_oe, c_v, c_busy, c_bc, d_oe, d_v, d_busy, d_bc;

   sdr_dq_pipe #(.DSIZE(16), .CAS_LATENCY(3), .BURST_LEN(8)) u_a (
      .CLK(CLK), .RESET(RESET), .DATAIN(din[15:0]), .DM(dm[1:0]), .WR_EN(wr), .RD_CMD(rd),
      .DQIN(dqin[15:0]), .DQOUT(a_dqout), .DQM(a_dqm), .DQ_OE(a_oe), .RDATA(a_rdata),
      .RDATA_VALID(a_v), .RD_BUSY(a_busy), .BUS_CONFLICT(a_bc));
   sdr_dq_pipe #(.DSIZE(16), .CAS_LATENCY(2), .BURST_LEN(8)) u_b (
      .CLK(CLK), .RESET(RESET), .DATAIN(din[15:0]), .DM(dm[1:0]), .WR_EN(wr), .RD_CMD(rd),
      .DQIN(dqin[15:0]), .DQOUT(b_dqout), .DQM(b_dqm), .DQ_OE(b_oe), .RDATA(b_rdata),
      .RDATA_VALID(b_v), .RD_BUSY(b_busy), .BUS_CONFLICT(b_bc));
   sdr_dq_pipe #(.DSIZE(32), .CAS_LATENCY(2), .BURST_LEN(1)) u_c (
      .CLK(CLK), .RESET(RESET), .DATAIN(din), .DM(dm), .WR_EN(wr), .RD_CMD(rd),
      .DQIN(dqin), .DQOUT(c_dqout), .DQM(c_dqm), .DQ_OE(c_oe), .RDATA(c_rdata),
      .RDATA_VALID(c_v), .RD_BUSY(c_busy), .BUS_CONFLICT(c_bc));
   sdr_dq_pipe #(.DSIZE(32), .CAS_LATENCY(3), .BURST_LEN(1)) u_d (
      .CLK(CLK), .RESET(RESET), .DATAIN(din), .DM(dm), .WR_EN(wr), .RD_CMD(rd),
      .DQIN(dqin), .DQOUT(d_dqout), .DQM(d_dqm), .DQ_OE(d_oe), .RDATA(d_rdata),
      .RDATA_VALID(d_v), .RD_BUSY(d_busy), .BUS_CONFLICT(d_bc));

   logic [31:0] o_dqout [NCFG];
   logic [31:0] o_rdata [NCFG];
   logic [3:0]  o_dqm   [NCFG];
   logic        o_oe    [NCFG];
   logic        o_v     [NCFG];
   logic        o_busy  [NCFG];
   logic        o_bc    [NCFG];

   assign o_dqout[0] = {16'h0, a_dqout};  assign o_rdata[0] = {16'h0, a_rdata};
   assign o_dqout[1] = {16'h0, b_dqout};  assign o_rdata[1] = {16'h0, b_rdata};
   assign o_dqout[2] = c_dqout;           assign o_rdata[2] = c_rdata;
   assign o_dqout[3] = d_dqout;           assign o_rdata[3] = d_rdata;
   assign o_dqm[0] = {2'b00, a_dqm};      assign o_dqm[1] = {2'b00, b_dqm};
   assign o_dqm[2] = c_dqm;               assign o_dqm[3] = d_dqm;
   assign o_oe[0] = a_oe;   assign o_oe[1] = b_oe;   assign o_oe[2] = c_oe;   assign o_oe[3] = d_oe;
   assign o_v[0]  = a_v;    assign o_v[1]  = b_v;    assign o_v[2]  = c_v;    assign o_v[3]  = d_v;
   assign o_busy[0] = a_busy; assign o_busy[1] = b_busy; assign o_busy[2] = c_busy; assign o_busy[3] = d_busy;
   assign o_bc[0] = a_bc;   assign o_bc[1] = b_bc;   assign o_bc[2] = c_bc;   assign o_bc[3] = d_bc;

   // Reference model: which cycles issue a read beat, plus last write values
   bit          issue [NCFG][MAXC];
   logic [31:0] dqin_h [MAXC];
   logic [31:0] e_dqout [NCFG];
   logic [31:0] e_rdata [NCFG];
   logic [3:0]  e_dqm   [NCFG];
   bit          e_oe    [NCFG];
   bit          e_bc    [NCFG];

   int errors = 0;
   int checks = 0;
   int t;

   function automatic int cl_of(input int c);
      return (c == 0 || c == 3) ? 3 : 2;
   endfunction
   function automatic int bl_of(input int c);
      return (c < 2) ? 8 : 1;
   endfunction
   function automatic logic [31:0] dmask(input int c);
      return (c < 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [3:0] mones(input int c);
      return (c < 2) ? 4'h3 : 4'hF;
   endfunction

   // Beat issued at cycle j is presented at j+CL+1.
   function automatic bit m_valid(input int c, input int cyc);
      int j;
      j = cyc - cl_of(c) - 1;
      return (j >= 0) && issue[c][j];
   endfunction
   // Busy from the cycle after a beat issues until one cycle after it is presented.
   function automatic bit m_busy(input int c, input int cyc);
      for (int j = cyc - cl_of(c) - 2; j <= cyc - 1; j++)
         if (j >= 0 && issue[c][j]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_reset();
      for (int c = 0; c < NCFG; c++) begin
         for (int j = 0; j < MAXC; j++) issue[c][j] = 1'b0;
         e_dqout[c] = '0;
         e_rdata[c] = '0;
         e_dqm[c]   = mones(c);
         e_oe[c]    = 1'b0;
         e_bc[c]    = 1'b0;
      end
   endtask

   task automatic m_step(input int cyc);
      bit act, conf, legal;
      dqin_h[cyc] = dqin;
      for (int c = 0; c < NCFG; c++) begin
         if (rd)
            for (int k = 0; k < bl_of(c); k++) issue[c][cyc + k] = 1'b1;
         act   = issue[c][cyc];
         conf  = wr && (m_busy(c, cyc) || rd);
         legal = wr && !conf;
         if (legal) begin
            e_dqout[c] = din & dmask(c);
            e_dqm[c]   = dm & mones(c);
         end else begin
            e_dqm[c] = act ? 4'h0 : mones(c);
         end
         e_oe[c] = legal;
         if (conf) e_bc[c] = 1'b1;
         if (m_valid(c, cyc + 1)) e_rdata[c] = dqin_h[cyc] & dmask(c);
      end
   endtask

   task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cfg%0d cycle %0d: got %h expected %h", nm, c, t, got, exp);
      end
   endtask

   // Hand-computed value: pins both the DUT and the model.
   task automatic lit(input string nm, input int c, input logic [31:0] dut_v,
                      input logic [31:0] mod_v, input logic [31:0] exp);
      chk(nm, c, dut_v, exp);
      chk({"model_", nm}, c, mod_v, exp);
   endtask

   task automatic compare_all();
      for (int c = 0; c < NCFG; c++) begin
         chk("dqout", c, o_dqout[c], e_dqout[c]);
         chk("dqm", c, {28'h0, o_dqm[c]}, {28'h0, e_dqm[c]});
         chk("dq_oe", c, {31'h0, o_oe[c]}, {31'h0, e_oe[c]});
         chk("rdata", c, o_rdata[c], e_rdata[c]);
         chk("rdata_valid", c, {31'h0, o_v[c]}, {31'h0, m_valid(c, t)});
         chk("rd_busy", c, {31'h0, o_busy[c]}, {31'h0, m_busy(c, t)});
         chk("bus_conflict", c, {31'h0, o_bc[c]}, {31'h0, e_bc[c]});
      end
   endtask

   function automatic logic [31:0] b2w(input bit b);
      return {31'h0, b};
   endfunction

   task automatic directed_checks(input int rel);
      logic [3:0] dm_tab [4];
      dm_tab = '{4'h0, 4'h1, 4'h2, 4'h0};
      if (rel >= 1 && rel <= 4) begin
         lit("wr_dqout", 0, o_dqout[0], e_dqout[0], 32'h1111 * rel);
         lit("wr_dqm", 0, {28'h0, o_dqm[0]}, {28'h0, e_dqm[0]}, {28'h0, dm_tab[rel-1]});
         lit("wr_oe", 0, b2w(o_oe[0]), b2w(e_oe[0]), 32'd1);
      end
      case (rel)
         5: begin
            lit("wr_oe_end", 0, b2w(o_oe[0]), b2w(e_oe[0]), 32'd0);
            lit("idle_dqm", 0, {28'h0, o_dqm[0]}, {28'h0, e_dqm[0]}, 32'h3);
         end
         10: lit("busy_pre", 0, b2w(o_busy[0]), b2w(m_busy(0, t)), 32'd0);
         11: lit("busy_rise", 0, b2w(o_busy[0]), b2w(m_busy(0, t)), 32'd1);
         13: begin
            lit("rv_early", 0, b2w(o_v[0]), b2w(m_valid(0, t)), 32'd0);
            lit("conf_oe", 0, b2w(o_oe[0]), b2w(e_oe[0]), 32'd0);
            lit("conf_flag", 0, b2w(o_bc[0]), b2w(e_bc[0]), 32'd1);
            lit("bl1_valid", 2, b2w(o_v[2]), b2w(m_valid(2, t)), 32'd1);
            lit("bl1_rdata", 2, o_rdata[2], e_rdata[2], 32'd12);
         end
         14: begin
            lit("rv_first", 0, b2w(o_v[0]), b2w(m_valid(0, t)), 32'd1);
            lit("rd_first", 0, o_rdata[0], e_rdata[0], 32'd13);
            lit("bl1_single", 2, b2w(o_v[2]), b2w(m_valid(2, t)), 32'd0);
            lit("bl1_valid", 3, b2w(o_v[3]), b2w(m_valid(3, t)), 32'd1);
            lit("bl1_rdata", 3, o_rdata[3], e_rdata[3], 32'd13);
         end
         15: lit("bl1_single", 3, b2w(o_v[3]), b2w(m_valid(3, t)), 32'd0);
         21: begin
            lit("rv_last", 0, b2w(o_v[0]), b2w(m_valid(0, t)), 32'd1);
            lit("rd_last", 0, o_rdata[0], e_rdata[0], 32'd20);
         end
         22: begin
            lit("rv_after", 0, b2w(o_v[0]), b2w(m_valid(0, t)), 32'd0);
            lit("busy_tail", 0, b2w(o_busy[0]), b2w(m_busy(0, t)), 32'd1);
         end
         23: lit("busy_fall", 0, b2w(o_busy[0]), b2w(m_busy(0, t)), 32'd0);
         42: lit("int_pre", 1, b2w(o_v[1]), b2w(m_valid(1, t)), 32'd0);
         43: begin
            lit("int_first", 1, b2w(o_v[1]), b2w(m_valid(1, t)), 32'd1);
            lit("int_rd0", 1, o_rdata[1], e_rdata[1], 32'd42);
         end
         46: lit("int_join", 1, o_rdata[1], e_rdata[1], 32'd45);
         53: begin
            lit("int_last", 1, b2w(o_v[1]), b2w(m_valid(1, t)), 32'd1);
            lit("int_rd10", 1, o_rdata[1], e_rdata[1], 32'd52);
         end
         54: lit("int_end", 1, b2w(o_v[1]), b2w(m_valid(1, t)), 32'd0);
         71: begin
            lit("wrrd_oe", 0, b2w(o_oe[0]), b2w(e_oe[0]), 32'd0);
            lit("wrrd_flag", 0, b2w(o_bc[0]), b2w(e_bc[0]), 32'd1);
         end
         74: lit("wrrd_read", 0, o_rdata[0], e_rdata[0], 32'd73);
         101: begin
            lit("legal_oe", 0, b2w(o_oe[0]), b2w(e_oe[0]), 32'd1);
            lit("legal_dq", 0, o_dqout[0], e_dqout[0], 32'h5A5A);
            lit("sticky", 0, b2w(o_bc[0]), b2w(e_bc[0]), 32'd1);
         end
         115: begin
            lit("rst_dqout", 0, o_dqout[0], e_dqout[0], 32'd0);
            lit("rst_dqm", 0, {28'h0, o_dqm[0]}, {28'h0, e_dqm[0]}, 32'h3);
            lit("rst_dqm", 2, {28'h0, o_dqm[2]}, {28'h0, e_dqm[2]}, 32'hF);
            lit("rst_rdata", 0, o_rdata[0], e_rdata[0], 32'd0);
            lit("rst_bc", 0, b2w(o_bc[0]), b2w(e_bc[0]), 32'd0);
            lit("rst_busy", 0, b2w(o_busy[0]), b2w(m_busy(0, t)), 32'd0);
         end
         default: ;
      endcase
      if (rel >= 114 && rel <= 122)
         lit("abort_novalid", 0, b2w(o_v[0]), b2w(m_valid(0, t)), 32'd0);
   endtask

   task automatic drive_directed(input int rel);
      RESET = (rel == 113 || rel == 114);
      rd    = (rel == 10 || rel == 40 || rel == 43 || rel == 70 || rel == 110);
      wr    = 1'b0;
      din   = 32'h0;
      dm    = 4'h0;
      dqin  = rel;
      if (rel <= 3) begin
         wr  = 1'b1;
         din = 32'h1111 * (rel + 1);
         dm  = (rel == 1) ? 4'h1 : (rel == 2) ? 4'h2 : 4'h0;
      end else if (rel == 12) begin
         wr = 1'b1; din = 32'hDEAD;
      end else if (rel == 70) begin
         wr = 1'b1; din = 32'hBEEF;
      end else if (rel == 100) begin
         wr = 1'b1; din = 32'h5A5A;
      end
   endtask

   int rst_left = 0;

   task automatic drive_random();
      bit heavy_rd;
      heavy_rd = ((t / 64) % 2) == 1;
      if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = 2;
      RESET = (rst_left != 0);
      if (rst_left != 0) rst_left--;
      rd   = heavy_rd ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 29) == 0);
      wr   = heavy_rd ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      din  = $urandom;
      dm   = 4'($urandom_range(0, 15));
      dqin = $urandom;
   endtask

   initial begin
      RESET = 1'b1;
      rd = 1'b0; wr = 1'b0; din = '0; dm = '0; dqin = '0;
      m_reset();
      for (t = 0; t < NCYC; t++) begin
         @(posedge CLK);
         #1;
         compare_all();
         if (t >= T0 && t < T0 + 160) directed_checks(t - T0);
         if (t < T0) begin
            RESET = 1'b1; rd = 1'b0; wr = 1'b0;
         end else if (t < T0 + 160) begin
            drive_directed(t - T0);
         end else begin
            drive_random();
         end
         if (RESET) m_reset();
         else       m_step(t);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
